approx_mult_seq: RTL and testbench



---
 rtl/approx_mult_pkg.sv | 29 ++
 rtl/approx_mult_core.sv | 80 ++++++++
 rtl/approx_mult_seq.sv | 76 +++++++
 tb/tb_approx_mult_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate sequential multiplier (approx_mult_seq).
package approx_mult_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_t;

    // Approx mode clears the low approx_bits of each operand; exact mode keeps all bits.
    function automatic logic [MAX_WIDTH-1:0] operand_mask(input int approx_bits, input mode_t mode);
        logic [MAX_WIDTH-1:0] low;
        low = (MAX_WIDTH'(1) << approx_bits) - MAX_WIDTH'(1);
        return (mode == MODE_APPROX) ? ~low : '1;
    endfunction

    // Mean of the dropped low x low partial product: 2^(2*approx_bits-2).
    function automatic logic [2*MAX_WIDTH-1:0] bias_const(input int approx_bits);
        return (2*MAX_WIDTH)'(1) << (2*approx_bits - 2);
    endfunction

endpackage

// File: rtl/approx_mult_core.sv
// Shift-add datapath: masked operand registers, accumulator and bit index counter.
// Optional error compensation is built only when APPROX_MULT_ERRCOMP_EN is defined.
module approx_mult_core
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               approx,
    output logic [2*WIDTH-1:0] product,
    output logic               approx_q,
    output logic               zero,
    output logic               last
);

    localparam int PW = 2 * WIDTH;
    localparam int IW = $clog2(WIDTH);

    mode_t            mode_sel;
    mode_t            mode_q;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;
    logic [IW-1:0]    start_idx;
    logic [PW-1:0]    acc_init;
    logic [PW-1:0]    a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [IW-1:0]    idx;
    logic [PW-1:0]    acc;

    assign mode_sel  = approx ? MODE_APPROX : MODE_EXACT;
    assign mask      = WIDTH'(operand_mask(APPROX_BITS, mode_sel));
    assign a_m       = a & mask;
    assign b_m       = b & mask;
    assign start_idx = (mode_sel == MODE_APPROX) ? IW'(APPROX_BITS) : '0;
    assign zero      = (a_m == '0) || (b_m == '0);

    // Bias is folded into the starting accumulator; the sum at DONE entry is identical
    // and the zero-shortcut path picks it up for free.
`ifdef APPROX_MULT_ERRCOMP_EN
    assign acc_init = (mode_sel == MODE_APPROX) ? PW'(bias_const(APPROX_BITS)) : '0;
`else
    assign acc_init = '0;
`endif

    // NOTE: datapath registers are reset too, because out_product is visible and must read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            idx    <= '0;
            acc    <= '0;
            mode_q <= MODE_EXACT;
        end else if (load) begin
            a_sh   <= PW'(a_m) << start_idx;
            b_sh   <= b_m >> start_idx;
            idx    <= start_idx;
            acc    <= acc_init;
            mode_q <= mode_sel;
        end else if (step) begin
            if (b_sh[0]) begin
                acc <= acc + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            idx  <= idx + IW'(1);
        end
    end

    assign last     = (idx == IW'(WIDTH - 1));
    assign product  = acc;
    assign approx_q = (mode_q == MODE_APPROX);

endmodule

// File: rtl/approx_mult_seq.sv
// Iterative shift-add unsigned multiplier with exact/approximate mode and valid/ready handshakes.
// Define APPROX_MULT_ERRCOMP_EN to add bias compensation to approximate results.
module approx_mult_seq
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_approx,
    output logic               busy
);

    generate
        if (APPROX_BITS < 1 || APPROX_BITS > WIDTH - 1) begin : g_bad_approx_bits
            $error("approx_mult_seq: APPROX_BITS must lie in 1..WIDTH-1");
        end
        if (WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("approx_mult_seq: WIDTH exceeds MAX_WIDTH");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0] state;
    logic       load;
    logic       zero;
    logic       last;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_BUSY);
    assign out_valid = (state == ST_DONE);
    assign load      = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (load)      state <= zero ? ST_DONE : ST_BUSY;
                ST_BUSY: if (last)      state <= ST_DONE;
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default:                state <= ST_IDLE;
            endcase
        end
    end

    approx_mult_core #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (busy),
        .a        (in_a),
        .b        (in_b),
        .approx   (in_approx),
        .product  (out_product),
        .approx_q (out_approx),
        .zero     (zero),
        .last     (last)
    );

endmodule

// File: tb/tb_approx_mult_seq.sv
// Directed testbench for approx_mult_seq (WIDTH=16, APPROX_BITS=8); honours APPROX_MULT_ERRCOMP_EN.
module tb_approx_mult_seq;

`ifdef APPROX_MULT_ERRCOMP_EN
    localparam logic [31:0] BIAS = 32'h0000_4000;
`else
    localparam logic [31:0] BIAS = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_approx;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic        out_approx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ap;
        logic [31:0] prod;
        int          lat;   // edges after the accepting edge until out_valid is seen
    } vec_t;

    vec_t vecs[12];

    approx_mult_seq #(.WIDTH(16), .APPROX_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_approx   (in_approx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_approx  (out_approx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic ap);
        logic [15:0] m;
        m = ap ? 16'hFF00 : 16'hFFFF;
        return ({16'h0, a & m} * {16'h0, b & m}) + (ap ? BIAS : 32'h0);
    endfunction

    function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b, input logic ap);
        logic [15:0] m;
        m = ap ? 16'hFF00 : 16'hFFFF;
        if ((a & m) == 16'h0 || (b & m) == 16'h0) return 0;
        return ap ? 8 : 16;
    endfunction

    // Entered at a negedge; leaves at the negedge right after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ap);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_ready: actual=in_ready low required=in_ready high");
        end
        in_a      = a;
        in_b      = b;
        in_approx = ap;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_approx = ~ap;    // must not affect the operation in flight
    endtask

    task automatic wait_valid(output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ok = out_valid;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: actual=no out_valid required=out_valid within 40 edges");
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        bit ok;
        issue(v.a, v.b, v.ap);
        wait_valid(lat, ok);
        if (ok) begin
            check({name, "_lat"}, 32'(lat), 32'(v.lat));
            check({name, "_prod"}, out_product, v.prod);
            check({name, "_mode"}, {31'h0, out_approx}, {31'h0, v.ap});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        bit ok;
        int seen;
        logic [15:0] ba[4];
        logic [15:0] bb[4];
        logic        bap[4];

        vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 32'h0626_0060,        16};
        vecs[1]  = '{16'h1234, 16'h5678, 1'b1, 32'h060C_0000 + BIAS,  8};
        vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001,        16};
        vecs[3]  = '{16'h00FF, 16'h1234, 1'b1, 32'h0000_0000 + BIAS,  0};
        vecs[4]  = '{16'h0003, 16'h0005, 1'b0, 32'h0000_000F,        16};
        vecs[5]  = '{16'h0001, 16'h8000, 1'b0, 32'h0000_8000,        16};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'hFE01_0000 + BIAS,  8};
        vecs[7]  = '{16'h0000, 16'h1234, 1'b0, 32'h0000_0000,         0};
        vecs[8]  = '{16'h1234, 16'h00FF, 1'b1, 32'h0000_0000 + BIAS,  0};
        vecs[9]  = '{16'h8000, 16'h0100, 1'b1, 32'h0080_0000 + BIAS,  8};
        vecs[10] = '{16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01,        16};
        vecs[11] = '{16'h0100, 16'h0100, 1'b1, 32'h0001_0000 + BIAS,  8};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 16'h0;
        in_b      = 16'h0;
        in_approx = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready",  {31'h0, in_ready},   32'h1);
        check("rst_out_valid", {31'h0, out_valid},  32'h0);
        check("rst_product",   out_product,         32'h0);
        check("rst_out_approx",{31'h0, out_approx}, 32'h0);
        check("rst_busy",      {31'h0, busy},       32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held, inputs ignored while out_ready is low.
        out_ready = 1'b0;
        issue(16'h1234, 16'h5678, 1'b0);
        wait_valid(lat, ok);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            in_a     = 16'h0003;
            in_b     = 16'h0005;
            @(posedge clk);
            @(negedge clk);
            check("bp_valid",    {31'h0, out_valid}, 32'h1);
            check("bp_prod",     out_product,        32'h0626_0060);
            check("bp_in_ready", {31'h0, in_ready},  32'h0);
            check("bp_busy",     {31'h0, busy},      32'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", {31'h0, out_valid}, 32'h0);
        check("bp_release_ready", {31'h0, in_ready},  32'h1);

        // Asynchronous reset after 5 BUSY iterations of an exact op.
        issue(16'h1234, 16'h5678, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_in_ready",  {31'h0, in_ready},   32'h1);
        check("midrst_out_valid", {31'h0, out_valid},  32'h0);
        check("midrst_product",   out_product,         32'h0);
        check("midrst_out_approx",{31'h0, out_approx}, 32'h0);
        check("midrst_busy",      {31'h0, busy},       32'h0);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_valid", 32'(seen), 32'h0);
        run_vec('{16'h0003, 16'h0005, 1'b0, 32'h0000_000F, 16}, "after_rst");

        // Back-to-back: in_valid held high across four transactions in mixed modes.
        for (int k = 0; k < 4; k++) begin
            ba[k]  = 16'($urandom);
            bb[k]  = 16'($urandom);
            bap[k] = k[0];
        end
        in_a      = ba[0];
        in_b      = bb[0];
        in_approx = bap[0];
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b2b%0d_ready", k), {31'h0, in_ready}, 32'h1);
            @(posedge clk);
            @(negedge clk);
            if (k < 3) begin
                in_a      = ba[k+1];
                in_b      = bb[k+1];
                in_approx = bap[k+1];
            end else begin
                in_valid = 1'b0;
            end
            wait_valid(lat, ok);
            if (ok) begin
                check($sformatf("b2b%0d_lat", k),  32'(lat), 32'(ref_lat(ba[k], bb[k], bap[k])));
                check($sformatf("b2b%0d_prod", k), out_product, ref_prod(ba[k], bb[k], bap[k]));
                check($sformatf("b2b%0d_mode", k), {31'h0, out_approx}, {31'h0, bap[k]});
            end
            @(posedge clk);
            @(negedge clk);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("b2b_no_extra", 32'(seen), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
